// File: rtl/core_sequencer.sv
// Multi-cycle commit sequencer: gates PC/regfile, holds instructions across mem/mul handshakes, freezes on HALT.
// Strobes are combinational (Mealy). Wait states hold pc_en low until ack/done or timeout into FAULT.
module core_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       alu_control,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             mem_write,
  input  logic             done,
  input  logic             mem_ack,
  input  logic             mul_done,
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mul_start,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_MEM_WAIT = 3'd2;
  localparam logic [2:0] S_MUL_WAIT = 3'd3;
  localparam logic [2:0] S_HALTED   = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  logic [2:0]      state, state_nx;
  logic [TO_W-1:0] wait_cnt;
  logic            mem_we_q;
  logic            commit;
  logic            is_mem, is_mul, timed_out;

  assign is_mem    = mem_to_reg | mem_write;
  assign is_mul    = (alu_control == 6'd4) || (alu_control == 6'd5) || (alu_control == 6'd6);
  assign timed_out = (wait_cnt == TO_W'(TIMEOUT));
  assign busy      = (state == S_EXEC) || (state == S_MEM_WAIT) || (state == S_MUL_WAIT);

  always_comb begin
    state_nx  = state;
    commit    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mul_start = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_EXEC;
      S_EXEC: begin
        // HALT outranks every other op class and never commits.
        if (done) begin
          state_nx = S_HALTED;
        end else if (is_mem) begin
          mem_req = 1'b1;
          mem_we  = mem_write;
          if (mem_ack) commit   = 1'b1;
          else         state_nx = S_MEM_WAIT;
        end else if (is_mul) begin
          mul_start = 1'b1;
          state_nx  = S_MUL_WAIT;
        end else begin
          commit = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = mem_we_q;
        if (mem_ack) begin
          commit   = 1'b1;
          state_nx = S_EXEC;
        end else if (timed_out) begin
          state_nx = S_FAULT;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          commit   = 1'b1;
          state_nx = S_EXEC;
        end else if (timed_out) begin
          state_nx = S_FAULT;
        end
      end
      default: state_nx = state;
    endcase
  end

  assign pc_en  = commit;
  assign reg_we = commit & reg_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_we_q    <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state  <= state_nx;
      halted <= (state_nx == S_HALTED);
      fault  <= (state_nx == S_FAULT);
      // EXEC preloads 1 so the first wait cycle already counts toward the timeout.
      if (state == S_EXEC) begin
        wait_cnt <= TO_W'(1);
        mem_we_q <= mem_write;
      end else if (busy) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end
      if (busy)   cycle_count <= cycle_count + CNT_W'(1);
      if (commit) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-cycle strobe scoreboard plus counter/status checks.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, reg_write, mem_to_reg, mem_write, done, mem_ack, mul_done;
  logic [5:0]  alu_control;
  logic        pc_en, reg_we, mem_req, mem_we, mul_start, busy, halted, fault;
  logic [31:0] cycle_count, instr_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       st;
    logic [5:0] alu;
    logic       rw, m2r, mw, dn, ack, md;
  } stim_t;

  // expected strobes: {pc_en, reg_we, mem_req, mem_we, mul_start}
  logic [4:0] exp_q[$];

  core_sequencer #(.CNT_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .done(done), .mem_ack(mem_ack), .mul_done(mul_done),
    .pc_en(pc_en), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
    .mul_start(mul_start), .busy(busy), .halted(halted), .fault(fault),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic st, input logic [5:0] alu, input logic rw,
                               input logic m2r, input logic mw, input logic dn,
                               input logic ack, input logic md);
    stim_t s;
    s.st = st; s.alu = alu; s.rw = rw; s.m2r = m2r; s.mw = mw; s.dn = dn; s.ack = ack; s.md = md;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    start = s.st; alu_control = s.alu; reg_write = s.rw; mem_to_reg = s.m2r;
    mem_write = s.mw; done = s.dn; mem_ack = s.ack; mul_done = s.md;
  endtask

  function automatic logic [4:0] strobes();
    return {pc_en, reg_we, mem_req, mem_we, mul_start};
  endfunction

  task automatic test_reset();
    apply(mk(0, 6'd0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #2;
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_flags halted=%b fault=%b want 0 0", halted, fault); end
    checks++; if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin failures++; $display("FAIL reset_counts cyc=%0d ins=%0d want 0 0", cycle_count, instr_count); end
    checks++; if (strobes() !== 5'b00000 || busy !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b busy=%b want 00000 0", strobes(), busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_start();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    sq.push_back(mk(1, 6'd0, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b00000);
    for (int i = 0; i < 3; i++) begin sq.push_back(mk(0, 6'd0, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b11000); end
    foreach (sq[i]) begin
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL start row%0d strobes=%b want %b", i, got, e); end
      @(negedge clk);
    end
    checks++; if (instr_count !== 32'd3 || cycle_count !== 32'd3) begin failures++; $display("FAIL start_counts ins=%0d cyc=%0d want 3 3", instr_count, cycle_count); end
  endtask

  task automatic test_load_wait();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    for (int i = 0; i < 4; i++) begin sq.push_back(mk(0, 6'd0, 1, 1, 0, 0, 0, 0)); exp_q.push_back(5'b00100); end
    sq.push_back(mk(0, 6'd0, 1, 1, 0, 0, 1, 0)); exp_q.push_back(5'b11100);
    foreach (sq[i]) begin
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL load row%0d strobes=%b want %b", i, got, e); end
      @(negedge clk);
    end
    checks++; if (instr_count !== 32'd4 || cycle_count !== 32'd8) begin failures++; $display("FAIL load_counts ins=%0d cyc=%0d want 4 8", instr_count, cycle_count); end
  endtask

  task automatic test_store_zero_wait();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    sq.push_back(mk(0, 6'd0, 0, 0, 1, 0, 1, 0)); exp_q.push_back(5'b10110);
    sq.push_back(mk(0, 6'd0, 0, 0, 0, 0, 1, 0)); exp_q.push_back(5'b10000);
    foreach (sq[i]) begin
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL store row%0d strobes=%b want %b", i, got, e); end
      @(negedge clk);
    end
    checks++; if (instr_count !== 32'd6 || cycle_count !== 32'd10) begin failures++; $display("FAIL store_counts ins=%0d cyc=%0d want 6 10", instr_count, cycle_count); end
  endtask

  task automatic test_multiply();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    sq.push_back(mk(0, 6'd6, 1, 0, 0, 0, 0, 1)); exp_q.push_back(5'b00001);
    sq.push_back(mk(0, 6'd6, 1, 0, 0, 0, 1, 0)); exp_q.push_back(5'b00000);
    sq.push_back(mk(0, 6'd6, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b00000);
    sq.push_back(mk(0, 6'd6, 1, 0, 0, 0, 0, 1)); exp_q.push_back(5'b11000);
    sq.push_back(mk(0, 6'd5, 0, 0, 0, 0, 0, 0)); exp_q.push_back(5'b00001);
    sq.push_back(mk(0, 6'd5, 0, 0, 0, 0, 0, 1)); exp_q.push_back(5'b10000);
    sq.push_back(mk(0, 6'd4, 1, 0, 0, 0, 0, 1)); exp_q.push_back(5'b00001);
    sq.push_back(mk(0, 6'd4, 1, 0, 0, 0, 0, 1)); exp_q.push_back(5'b11000);
    sq.push_back(mk(0, 6'd7, 1, 0, 0, 0, 0, 1)); exp_q.push_back(5'b11000);
    foreach (sq[i]) begin
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL mul row%0d strobes=%b want %b", i, got, e); end
      @(negedge clk);
    end
    checks++; if (instr_count !== 32'd10 || cycle_count !== 32'd19) begin failures++; $display("FAIL mul_counts ins=%0d cyc=%0d want 10 19", instr_count, cycle_count); end
  endtask

  task automatic test_timeout();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    for (int i = 0; i < 5; i++) begin sq.push_back(mk(0, 6'd0, 1, 1, 0, 0, 0, 0)); exp_q.push_back(5'b00100); end
    for (int i = 0; i < 3; i++) begin sq.push_back(mk(1, 6'd0, 1, 1, 0, 0, 1, 1)); exp_q.push_back(5'b00000); end
    foreach (sq[i]) begin
      if (i == 4) begin
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_early fault=%b want 0", fault); end
      end
      if (i == 5) begin
        checks++; if (fault !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fault_set fault=%b busy=%b want 1 0", fault, busy); end
      end
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL timeout row%0d strobes=%b want %b", i, got, e); end
      @(negedge clk);
    end
    checks++; if (fault !== 1'b1 || instr_count !== 32'd10 || cycle_count !== 32'd24) begin
      failures++; $display("FAIL fault_hold fault=%b ins=%0d cyc=%0d want 1 10 24", fault, instr_count, cycle_count); end
    rst = 1'b1;
    #2;
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_clear fault=%b want 0", fault); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rst_midwait();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    sq.push_back(mk(1, 6'd0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(5'b00000);
    sq.push_back(mk(0, 6'd0, 0, 0, 1, 0, 0, 0)); exp_q.push_back(5'b00110);
    sq.push_back(mk(0, 6'd0, 0, 0, 1, 0, 0, 0)); exp_q.push_back(5'b00110);
    foreach (sq[i]) begin
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL midwait row%0d strobes=%b want %b", i, got, e); end
      if (i < 2) @(negedge clk);
    end
    apply(mk(0, 6'd0, 0, 0, 1, 0, 1, 0));
    rst = 1'b1;
    #1;
    checks++; if (strobes() !== 5'b00000 || busy !== 1'b0 || instr_count !== 32'd0) begin
      failures++; $display("FAIL midwait_rst strobes=%b busy=%b ins=%0d want 00000 0 0", strobes(), busy, instr_count); end
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 6'd0, 1, 0, 0, 0, 1, 0)); #2;
    checks++; if (strobes() !== 5'b00000 || busy !== 1'b0) begin failures++; $display("FAIL midwait_idle strobes=%b busy=%b want 00000 0", strobes(), busy); end
    @(negedge clk);
  endtask

  task automatic test_halt();
    stim_t sq[$]; logic [4:0] e; logic [4:0] got;
    sq.push_back(mk(1, 6'd0, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b00000);
    sq.push_back(mk(0, 6'd0, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b11000);
    sq.push_back(mk(0, 6'd0, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b11000);
    sq.push_back(mk(0, 6'd0, 1, 1, 0, 1, 1, 0)); exp_q.push_back(5'b00000);
    sq.push_back(mk(1, 6'd0, 1, 0, 0, 0, 0, 0)); exp_q.push_back(5'b00000);
    sq.push_back(mk(1, 6'd6, 1, 0, 0, 0, 0, 1)); exp_q.push_back(5'b00000);
    foreach (sq[i]) begin
      if (i == 3) begin
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_early halted=%b want 0", halted); end
      end
      if (i == 4) begin
        checks++; if (halted !== 1'b1 || instr_count !== 32'd2) begin failures++; $display("FAIL halt_set halted=%b ins=%0d want 1 2", halted, instr_count); end
      end
      apply(sq[i]); #2; got = strobes(); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL halt row%0d strobes=%b want %b", i, got, e); end
      @(negedge clk);
    end
    checks++; if (halted !== 1'b1 || instr_count !== 32'd2 || cycle_count !== 32'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL halt_frozen halted=%b ins=%0d cyc=%0d busy=%b want 1 2 3 0", halted, instr_count, cycle_count, busy); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_reset_start();
    test_load_wait();
    test_store_zero_wait();
    test_multiply();
    test_timeout();
    test_rst_midwait();
    test_reset();
    test_halt();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
